// File: rtl/toggle_scheduler_pkg.sv
// Shared constants for the toggle scheduler.
// FSM encodings and default bank geometry.
package toggle_scheduler_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PARK = 2'd2;

    localparam int N_CH_DEF = 4;
    localparam int PW_DEF   = 8;

endpackage

// File: rtl/toggle_scheduler_cell.sv
// Single T flip-flop used as one output channel.
// Inverts q on every edge where t is high.
module toggle_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/toggle_scheduler.sv
// Bank of period-counted toggle channels with an
// IDLE/RUN/PARK sequencer and an idle-only config port.
module toggle_scheduler
    import toggle_scheduler_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int PW   = PW_DEF,
    parameter int CHW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [PW-1:0]   cfg_period,
    input  logic            cfg_en,
    input  logic            start,
    input  logic            stop,
    output logic            busy,
    output logic [N_CH-1:0] q,
    output logic [N_CH-1:0] tick
);

    logic [1:0]      state;
    logic [PW-1:0]   period [N_CH];
    logic [PW-1:0]   cnt    [N_CH];
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] active;
    logic            cfg_fire;

    assign cfg_ready = (state == ST_IDLE) && !start;
    assign busy      = (state != ST_IDLE);
    assign cfg_fire  = cfg_valid && cfg_ready;

    always_comb begin
        active = '0;
        for (int i = 0; i < N_CH; i++) begin
            active[i] = en[i] && (period[i] != '0);
        end
    end

    // In PARK every high output is fed back to its own t input.
    always_comb begin
        tick = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (state)
                ST_RUN:  tick[i] = active[i] && (cnt[i] == '0);
                ST_PARK: tick[i] = q[i];
                default: tick[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_RUN;
                ST_RUN:  if (stop)  state <= ST_PARK;
                ST_PARK: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en <= '0;
            for (int i = 0; i < N_CH; i++) begin
                period[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_fire && (cfg_ch == CHW'(i))) begin
                    period[i] <= cfg_period;
                    en[i]     <= cfg_en;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (state == ST_IDLE && start) begin
                    cnt[i] <= active[i] ? period[i] - PW'(1) : '0;
                end else if (state == ST_RUN && !stop && active[i]) begin
                    cnt[i] <= (cnt[i] == '0) ? period[i] - PW'(1)
                                             : cnt[i] - PW'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cell
        toggle_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (tick[g]),
            .q   (q[g])
        );
    end

endmodule

// File: tb/tb_toggle_scheduler.sv
// Directed bench for toggle_scheduler with a queued
// scoreboard of closed-form expected outputs.
module tb_toggle_scheduler;

    typedef logic [7:0] per_t [4];
    typedef struct {
        logic [3:0] q;
        logic [3:0] tick;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_period = '0;
    logic       cfg_en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy;
    logic [3:0] q;
    logic [3:0] tick;

    logic       c3_valid = 1'b0;
    logic       c3_ready;
    logic [1:0] c3_ch = '0;
    logic [7:0] c3_period = '0;
    logic       c3_en = 1'b0;
    logic       c3_start = 1'b0;
    logic       c3_stop = 1'b0;
    logic       c3_busy;
    logic [2:0] c3_q;
    logic [2:0] c3_tick;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    per_t pv;

    always #5 clk = ~clk;

    toggle_scheduler #(.N_CH(4), .PW(8), .CHW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .q          (q),
        .tick       (tick)
    );

    toggle_scheduler #(.N_CH(3), .PW(8), .CHW(2)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (c3_valid),
        .cfg_ready  (c3_ready),
        .cfg_ch     (c3_ch),
        .cfg_period (c3_period),
        .cfg_en     (c3_en),
        .start      (c3_start),
        .stop       (c3_stop),
        .busy       (c3_busy),
        .q          (c3_q),
        .tick       (c3_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, " q"}, 32'(q), 32'(e.q));
            chk({tag, " tick"}, 32'(tick), 32'(e.tick));
            chk({tag, " busy"}, 32'(busy), 32'(e.busy));
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] p,
                      input logic e);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_period = p;
        cfg_en     = e;
        #1;
        chk("wr cfg_ready", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    // Expected q in cycle n after the start edge is floor(n/P) mod 2;
    // tick is high in the cycle just before each P-th edge.
    function automatic exp_t model(input per_t p, input int n);
        exp_t e;
        e.q    = '0;
        e.tick = '0;
        e.busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (p[i] != 0) begin
                e.q[i]    = ((n / int'(p[i])) % 2) == 1;
                e.tick[i] = ((n + 1) % int'(p[i])) == 0;
            end
        end
        return e;
    endfunction

    task automatic run_bank(input string tag, input per_t p,
                            input int ncyc, input bit hold);
        if (hold) begin
            cfg_valid  = 1'b1;
            cfg_ch     = 2'd0;
            cfg_period = 8'd7;
            cfg_en     = 1'b1;
        end
        start = 1'b1;
        #1;
        if (hold) chk({tag, " ready_w_start"}, 32'(cfg_ready), 32'd0);
        step();
        start = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            if (hold) chk({tag, " ready_run"}, 32'(cfg_ready), 32'd0);
            sb.push_back(model(p, n));
            sb_check($sformatf("%s n%0d", tag, n));
            if (n < ncyc - 1) step();
        end
    endtask

    task automatic stop_bank(input string tag, input per_t p,
                             input int n_end);
        exp_t e;
        e = model(p, n_end + 1);
        cfg_valid = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        sb.push_back('{q: e.q, tick: e.q, busy: 1'b1});
        sb_check({tag, " park"});
        step();
        sb.push_back('{q: 4'd0, tick: 4'd0, busy: 1'b0});
        sb_check({tag, " idle"});
        chk({tag, " ready_idle"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        #1;
        rst = 1'b0;
        step();
        sb.push_back('{q: 4'd0, tick: 4'd0, busy: 1'b0});
        sb_check("reset");
        chk("reset cfg_ready", 32'(cfg_ready), 32'd1);

        c3_valid  = 1'b1;
        c3_ch     = 2'd3;
        c3_period = 8'd1;
        c3_en     = 1'b1;
        #1;
        chk("n3 ch3 ready", 32'(c3_ready), 32'd1);
        step();
        c3_valid = 1'b0;
        c3_start = 1'b1;
        step();
        c3_start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            chk("n3 busy", 32'(c3_busy), 32'd1);
            chk("n3 q", 32'(c3_q), 32'd0);
            chk("n3 tick", 32'(c3_tick), 32'd0);
            step();
        end
        c3_stop = 1'b1;
        step();
        c3_stop = 1'b0;
        step();
        chk("n3 idle", 32'(c3_busy), 32'd0);

        wr(2'd0, 8'd1, 1'b1);
        wr(2'd1, 8'd3, 1'b1);
        wr(2'd2, 8'd0, 1'b1);
        wr(2'd3, 8'd5, 1'b0);
        pv = '{8'd1, 8'd3, 8'd0, 8'd0};
        run_bank("prog", pv, 40, 1'b1);
        stop_bank("prog", pv, 39);

        run_bank("rerun", pv, 10, 1'b0);
        stop_bank("rerun", pv, 9);

        wr(2'd0, 8'd2, 1'b1);
        wr(2'd1, 8'd0, 1'b1);
        pv = '{8'd2, 8'd0, 8'd0, 8'd0};
        run_bank("park_hi", pv, 3, 1'b0);
        stop_bank("park_hi", pv, 2);
        run_bank("park_lo", pv, 1, 1'b0);
        stop_bank("park_lo", pv, 0);

        run_bank("ss", pv, 3, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        stop = 1'b0;
        sb.push_back('{q: 4'd1, tick: 4'd1, busy: 1'b1});
        sb_check("ss park");
        step();
        start = 1'b0;
        sb.push_back('{q: 4'd0, tick: 4'd0, busy: 1'b0});
        sb_check("ss start_in_park");
        step();
        chk("ss stay_idle", 32'(busy), 32'd0);

        wr(2'd0, 8'd3, 1'b1);
        pv = '{8'd3, 8'd0, 8'd0, 8'd0};
        run_bank("mid", pv, 5, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("mid rst q", 32'(q), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst tick", 32'(tick), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid rst ready", 32'(cfg_ready), 32'd1);
        pv = '{8'd0, 8'd0, 8'd0, 8'd0};
        run_bank("cleared", pv, 6, 1'b0);
        stop_bank("cleared", pv, 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
